axi_lite_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave AXI4-Lite arbiter with a registered request/response bridge and round-robin fairness. It sits between the core's bus masters (IFU, LSU, and later DMA/debug) and the single memory/peripheral crossbar port. It is the generalised successor of the two-master bridge arbiter, with these additions:

- configurable master count and bus widths
- true round-robin arbitration
- a write request is accepted only as a complete AW+W pair
- an explicit response buffer
- grant status outputs

---
 rtl/axi_lite_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - N-master to 1-slave AXI4-Lite round-robin arbiter
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_ar*/s_r*          per-master read request/response (flattened, master i in slice i)
//   s_aw*/s_w*/s_b*     per-master write request/response (flattened)
//   s_rdata/s_rresp/s_bresp  shared response buses, valid where s_rvalid/s_bvalid is set
//   m_ar*/m_r*/m_aw*/m_w*/m_b*  downstream AXI4-Lite master channels
//   busy, grant_id, grant_is_write  grant status
module axi_lite_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = $clog2(NUM_MASTERS),
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
    input  logic [NUM_MASTERS-1:0]        s_arvalid,
    output logic [NUM_MASTERS-1:0]        s_arready,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    input  logic [NUM_MASTERS-1:0]        s_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_MASTERS-1:0]        s_awvalid,
    output logic [NUM_MASTERS-1:0]        s_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] s_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] s_wstrb,
    input  logic [NUM_MASTERS-1:0]        s_wvalid,
    output logic [NUM_MASTERS-1:0]        s_wready,
    output logic [NUM_MASTERS-1:0]        s_bvalid,
    input  logic [NUM_MASTERS-1:0]        s_bready,

    output logic [DATA_W-1:0]             s_rdata,
    output logic [1:0]                    s_rresp,
    output logic [1:0]                    s_bresp,

    output logic [ADDR_W-1:0]             m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [STRB_W-1:0]             m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,

    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          grant_is_write
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DELIVER} state_t;

    state_t                  state, state_next;
    logic [ID_W-1:0]         last, gid, win;
    logic                    found, win_wr, grant, is_wr;
    logic [NUM_MASTERS-1:0]  elig;
    logic                    ar_v, aw_v, w_v;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_data;
    logic [STRB_W-1:0]       req_strb;
    logic [DATA_W-1:0]       rsp_data;
    logic [1:0]              rsp_code;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_W-1:0] i);
        onehot = NUM_MASTERS'(1) << i;
    endfunction

    // A write only competes once both AW and W are presented together.
    assign elig = s_arvalid | (s_awvalid & s_wvalid);

    // Round-robin search starting just after the last granted index.
    // Reads win over writes from the same master.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        win    = last;
        win_wr = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last) + k) % NUM_MASTERS;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                win    = ID_W'(idx);
                win_wr = !s_arvalid[idx];
            end
        end
    end

    assign grant     = (state == IDLE) && found;
    assign s_arready = (grant && !win_wr) ? onehot(win) : '0;
    assign s_awready = (grant &&  win_wr) ? onehot(win) : '0;
    assign s_wready  = s_awready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ADDR;
            // Writes leave once both AW and W have each completed, in any order.
            ADDR:    if (is_wr) begin
                         if ((!aw_v || m_awready) && (!w_v || m_wready)) state_next = RESP;
                     end else if (m_arready) begin
                         state_next = RESP;
                     end
            RESP:    if (is_wr ? m_bvalid : m_rvalid) state_next = DELIVER;
            DELIVER: if (is_wr ? s_bready[gid] : s_rready[gid]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= ID_W'(NUM_MASTERS - 1);
            gid      <= '0;
            is_wr    <= 1'b0;
            ar_v     <= 1'b0;
            aw_v     <= 1'b0;
            w_v      <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_strb <= '0;
            rsp_data <= '0;
            rsp_code <= '0;
        end else begin
            if (grant) begin
                last     <= win;
                gid      <= win;
                is_wr    <= win_wr;
                req_addr <= win_wr ? s_awaddr[int'(win)*ADDR_W +: ADDR_W]
                                   : s_araddr[int'(win)*ADDR_W +: ADDR_W];
                req_data <= s_wdata[int'(win)*DATA_W +: DATA_W];
                req_strb <= s_wstrb[int'(win)*STRB_W +: STRB_W];
                ar_v     <= !win_wr;
                aw_v     <= win_wr;
                w_v      <= win_wr;
            end else begin
                if (ar_v && m_arready) ar_v <= 1'b0;
                if (aw_v && m_awready) aw_v <= 1'b0;
                if (w_v  && m_wready)  w_v  <= 1'b0;
            end
            if (state == RESP) begin
                if (!is_wr && m_rvalid) begin
                    rsp_data <= m_rdata;
                    rsp_code <= m_rresp;
                end
                if (is_wr && m_bvalid) rsp_code <= m_bresp;
            end
        end
    end

    assign m_araddr  = req_addr;
    assign m_arvalid = ar_v;
    assign m_awaddr  = req_addr;
    assign m_awvalid = aw_v;
    assign m_wdata   = req_data;
    assign m_wstrb   = req_strb;
    assign m_wvalid  = w_v;
    assign m_rready  = (state == RESP) && !is_wr;
    assign m_bready  = (state == RESP) &&  is_wr;

    assign s_rvalid  = (state == DELIVER && !is_wr) ? onehot(gid) : '0;
    assign s_bvalid  = (state == DELIVER &&  is_wr) ? onehot(gid) : '0;
    assign s_rdata   = rsp_data;
    assign s_rresp   = rsp_code;
    assign s_bresp   = rsp_code;

    assign busy           = (state != IDLE);
    assign grant_id       = gid;
    assign grant_is_write = is_wr;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - self-checking bench for axi_lite_rr_arbiter
module tb_axi_lite_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N*AW-1:0] s_araddr = '0;
    logic [N-1:0]    s_arvalid = '0, s_arready, s_rvalid, s_rready = '0;
    logic [N*AW-1:0] s_awaddr = '0;
    logic [N-1:0]    s_awvalid = '0, s_awready;
    logic [N*DW-1:0] s_wdata = '0;
    logic [N*SW-1:0] s_wstrb = '0;
    logic [N-1:0]    s_wvalid = '0, s_wready, s_bvalid, s_bready = '0;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp, s_bresp;
    logic [AW-1:0]   m_araddr, m_awaddr;
    logic            m_arvalid, m_arready = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic [1:0]      m_rresp = '0, m_bresp = '0;
    logic            m_rvalid = 1'b0, m_rready;
    logic            m_awvalid, m_awready = 1'b0;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wvalid, m_wready = 1'b0;
    logic            m_bvalid = 1'b0, m_bready;
    logic            busy, grant_is_write;
    logic [IW-1:0]   grant_id;

    axi_lite_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .grant_id(grant_id), .grant_is_write(grant_is_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // Reference model: index of last grant and the grant_id the status should show.
    int m_last = N - 1;
    int m_gid  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
        s_rready = '0;  s_bready = '0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b0;  m_bvalid = 1'b0;
    endtask

    // One transaction from the grant cycle through delivery. Waits are the number of
    // stall cycles before each handshake; drop clears the winner's granted valids.
    task automatic do_txn(input int a_wait, input int w_wait, input int r_wait, input int d_wait,
                          input logic [DW-1:0] rsp_d, input logic [1:0] rsp_c, input logic drop);
        int g, n, idx;
        logic found, rd;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [N-1:0]  junk;
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && (s_arvalid[idx] || (s_awvalid[idx] && s_wvalid[idx]))) begin
                found = 1'b1;
                g = idx;
            end
        end
        @(negedge clk);
        chk("grant_busy", busy, 0);
        chk("grant_id_hold", grant_id, m_gid);
        if (!found) begin
            chk("no_grant_ready", {s_arready, s_awready, s_wready}, 0);
            step();
            return;
        end
        rd = s_arvalid[g];
        ea = rd ? s_araddr[g*AW +: AW] : s_awaddr[g*AW +: AW];
        ed = s_wdata[g*DW +: DW];
        es = s_wstrb[g*SW +: SW];
        chk("grant_arready", s_arready, rd ? oh(g) : '0);
        chk("grant_awready", s_awready, rd ? '0 : oh(g));
        chk("grant_wready", s_wready, rd ? '0 : oh(g));
        step();
        m_last = g;
        m_gid  = g;
        if (drop) begin
            if (rd) s_arvalid[g] = 1'b0;
            else begin s_awvalid[g] = 1'b0; s_wvalid[g] = 1'b0; end
        end
        n = rd ? a_wait : (a_wait > w_wait ? a_wait : w_wait);
        for (int c = 0; c <= n; c++) begin
            m_arready = rd && (c == a_wait);
            m_awready = !rd && (c == a_wait);
            m_wready  = !rd && (c == w_wait);
            @(negedge clk);
            chk("addr_busy", busy, 1);
            chk("addr_gid", grant_id, g);
            chk("addr_is_wr", grant_is_write, !rd);
            chk("addr_quiet", {s_arready, s_awready, s_wready}, 0);
            if (rd) begin
                chk("arvalid", m_arvalid, 1);
                chk("araddr", m_araddr, ea);
            end else begin
                chk("awvalid", m_awvalid, c <= a_wait);
                chk("wvalid", m_wvalid, c <= w_wait);
                if (c <= a_wait) chk("awaddr", m_awaddr, ea);
                if (c <= w_wait) begin
                    chk("wdata", m_wdata, ed);
                    chk("wstrb", m_wstrb, es);
                end
            end
            step();
        end
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        for (int c = 0; c <= r_wait; c++) begin
            m_rvalid = rd && (c == r_wait);
            m_bvalid = !rd && (c == r_wait);
            m_rdata  = (c == r_wait) ? rsp_d : DW'($urandom);
            m_rresp  = (c == r_wait) ? rsp_c : 2'($urandom);
            m_bresp  = (c == r_wait) ? rsp_c : 2'($urandom);
            @(negedge clk);
            chk("resp_busy", busy, 1);
            chk("resp_rready", m_rready, rd);
            chk("resp_bready", m_bready, !rd);
            chk("resp_m_valids", {m_arvalid, m_awvalid, m_wvalid}, 0);
            chk("resp_s_valids", {s_rvalid, s_bvalid}, 0);
            chk("resp_quiet", {s_arready, s_awready, s_wready}, 0);
            step();
        end
        m_rvalid = 1'b0; m_bvalid = 1'b0;
        m_rdata = DW'($urandom); m_rresp = 2'($urandom); m_bresp = 2'($urandom);
        for (int c = 0; c <= d_wait; c++) begin
            junk = N'($urandom);
            junk[g] = 1'b0;
            s_rready = junk | ((rd && c == d_wait) ? oh(g) : '0);
            junk = N'($urandom);
            junk[g] = 1'b0;
            s_bready = junk | ((!rd && c == d_wait) ? oh(g) : '0);
            @(negedge clk);
            chk("dlv_busy", busy, 1);
            chk("dlv_rvalid", s_rvalid, rd ? oh(g) : '0);
            chk("dlv_bvalid", s_bvalid, rd ? '0 : oh(g));
            if (rd) begin
                chk("dlv_rdata", s_rdata, rsp_d);
                chk("dlv_rresp", s_rresp, rsp_c);
            end else begin
                chk("dlv_bresp", s_bresp, rsp_c);
            end
            chk("dlv_m_ready", {m_rready, m_bready}, 0);
            chk("dlv_quiet", {s_arready, s_awready, s_wready}, 0);
            step();
        end
        s_rready = '0; s_bready = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_is_wr", grant_is_write, 0);
        chk("rst_m_valid", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
        chk("rst_s_valid", {s_rvalid, s_bvalid, s_arready, s_awready, s_wready}, 0);
        rst = 1'b0;
        step();

        // All three masters request reads continuously: strict 0,1,2,0,1,2 rotation.
        for (int i = 0; i < N; i++) s_araddr[i*AW +: AW] = 32'h1000_0000 + i;
        s_arvalid = '1;
        for (int i = 0; i < 6; i++) begin
            do_txn(0, 0, 0, 0, DW'($urandom), 2'b00, 1'b0);
            chk("rr_order", grant_id, i % N);
        end
        clear_inputs();

        // Single zero-wait read from master 0.
        s_araddr[0 +: AW] = 32'h8000_0000;
        s_arvalid = 3'b001;
        do_txn(0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b1);
        chk("single_gid", grant_id, 0);
        clear_inputs();

        // Write from master 1 with AW two cycles ahead of W: no grant until W.
        s_awaddr[1*AW +: AW] = 32'h4000_0010;
        s_wdata[1*DW +: DW]  = 32'hCAFE_F00D;
        s_wstrb[1*SW +: SW]  = 4'hF;
        s_awvalid = 3'b010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("aw_only_ready", {s_arready, s_awready, s_wready}, 0);
            chk("aw_only_busy", busy, 0);
            step();
        end
        s_wvalid = 3'b010;
        do_txn(0, 0, 0, 0, '0, 2'b00, 1'b1);
        chk("wr1_gid", grant_id, 1);
        chk("wr1_is_wr", grant_is_write, 1);
        clear_inputs();

        // AW accepted three cycles before W; SLVERR passes through.
        s_awaddr[2*AW +: AW] = 32'h5000_0000;
        s_wdata[2*DW +: DW]  = 32'h1234_5678;
        s_wstrb[2*SW +: SW]  = 4'h5;
        s_awvalid = 3'b100;
        s_wvalid  = 3'b100;
        do_txn(0, 3, 0, 0, '0, 2'b10, 1'b1);
        clear_inputs();

        // Master 0 stalls delivery for 5 cycles while master 1 waits.
        s_araddr[0 +: AW] = 32'h0000_0100;
        s_araddr[1*AW +: AW] = 32'h0000_0200;
        s_arvalid = 3'b011;
        do_txn(1, 0, 2, 5, 32'h0BAD_CAFE, 2'b11, 1'b1);
        chk("hold_gid", grant_id, 0);
        do_txn(0, 0, 0, 0, 32'h0000_0001, 2'b00, 1'b1);
        chk("pending_gid", grant_id, 1);
        clear_inputs();

        // Reset pulsed while in RESP.
        s_araddr[2*AW +: AW] = 32'h0000_0300;
        s_arvalid = 3'b100;
        @(negedge clk);
        chk("rp_grant", s_arready, 3'b100);
        step();
        s_arvalid = '0;
        m_arready = 1'b1;
        @(negedge clk);
        chk("rp_arvalid", m_arvalid, 1);
        step();
        m_arready = 1'b0;
        @(negedge clk);
        chk("rp_in_resp", m_rready, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        m_last = N - 1;
        m_gid  = 0;
        @(negedge clk);
        chk("rp_busy", busy, 0);
        chk("rp_gid", grant_id, 0);
        chk("rp_is_wr", grant_is_write, 0);
        chk("rp_m", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
        chk("rp_s", {s_rvalid, s_bvalid, s_arready, s_awready, s_wready}, 0);
        step();
        s_arvalid = '1;
        do_txn(0, 0, 0, 0, DW'($urandom), 2'b00, 1'b1);
        chk("rp_first_gid", grant_id, 0);
        clear_inputs();

        // Randomized traffic checked against the round-robin model.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                s_araddr[i*AW +: AW] = AW'($urandom);
                s_awaddr[i*AW +: AW] = AW'($urandom);
                s_wdata[i*DW +: DW]  = DW'($urandom);
                s_wstrb[i*SW +: SW]  = SW'($urandom);
                s_arvalid[i] = ($urandom_range(0, 2) == 0);
                s_awvalid[i] = ($urandom_range(0, 1) == 0);
                s_wvalid[i]  = ($urandom_range(0, 1) == 0);
            end
            do_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), DW'($urandom), 2'($urandom), 1'($urandom));
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
